alu_operand_stack: RTL

- Operand stack that feeds the ALU and absorbs its result.
- Drives operand1 (next-on-stack, NOS) and operand2 (top-of-stack, TOS) to the ALU.
- Writes alu_result back on the clock edge, completing the single-cycle execute loop of the stack CPU.
- Also handles literal push, pop, dup, swap and clear, and keeps sticky overflow/underflow flags for the control unit.

---
 rtl/alu_operand_stack.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_operand_stack.sv
// Operand stack for the stack CPU: presents NOS/TOS to the ALU, absorbs the
// ALU result, and handles push/pop/dup/swap/clear with sticky error flags.
module alu_operand_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       stk_op,
  input  logic [WIDTH-1:0] push_data,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             err_clr,
  output logic [WIDTH-1:0] operand1,
  output logic [WIDTH-1:0] operand2,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_PUSH  = 3'b001,
    OP_POP   = 3'b010,
    OP_BINOP = 3'b011,
    OP_UNOP  = 3'b100,
    OP_DUP   = 3'b101,
    OP_SWAP  = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    nos_idx;
  logic [AW-1:0]    free_idx;
  logic             ge1;
  logic             ge2;
  logic [CW-1:0]    count_nx;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             do_swap;
  logic             ovf_err;
  logic             unf_err;

  assign op = op_e'(stk_op);

  // Index and occupancy helpers; indices wrap harmlessly when unused.
  always_comb begin
    free_idx = count[AW-1:0];
    top_idx  = free_idx - AW'(1);
    nos_idx  = free_idx - AW'(2);
    ge1      = (count != '0);
    ge2      = (count >= CW'(2));
    empty    = !ge1;
    full     = (count == FULL_CNT);
    operand2 = ge1 ? mem[top_idx] : '0;
    operand1 = ge2 ? mem[nos_idx] : '0;
  end

  // Decode the op: legality check against current count; illegal ops are suppressed.
  always_comb begin
    count_nx = count;
    wr_en    = 1'b0;
    wr_idx   = free_idx;
    wr_data  = push_data;
    do_swap  = 1'b0;
    ovf_err  = 1'b0;
    unf_err  = 1'b0;
    case (op)
      OP_NOP: ;
      OP_PUSH: begin
        if (full) ovf_err = 1'b1;
        else begin
          wr_en    = 1'b1;
          count_nx = count + CW'(1);
        end
      end
      OP_POP: begin
        if (!ge1) unf_err = 1'b1;
        else count_nx = count - CW'(1);
      end
      OP_BINOP: begin
        if (!ge2) unf_err = 1'b1;
        else begin
          wr_en    = 1'b1;
          wr_idx   = nos_idx;
          wr_data  = alu_result;
          count_nx = count - CW'(1);
        end
      end
      OP_UNOP: begin
        if (!ge1) unf_err = 1'b1;
        else begin
          wr_en   = 1'b1;
          wr_idx  = top_idx;
          wr_data = alu_result;
        end
      end
      OP_DUP: begin
        // Empty takes precedence so DUP at count==0 reports underflow only.
        if (!ge1) unf_err = 1'b1;
        else if (full) ovf_err = 1'b1;
        else begin
          wr_en    = 1'b1;
          wr_data  = mem[top_idx];
          count_nx = count + CW'(1);
        end
      end
      OP_SWAP: begin
        if (!ge2) unf_err = 1'b1;
        else do_swap = 1'b1;
      end
      OP_CLEAR: count_nx = '0;
      default: ;
    endcase
  end

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (do_swap) begin
      mem[top_idx] <= mem[nos_idx];
      mem[nos_idx] <= mem[top_idx];
    end
  end

  // Occupancy counter and sticky flags; a fresh error outranks err_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= count_nx;
      if (err_clr) begin
        overflow  <= ovf_err;
        underflow <= unf_err;
      end else begin
        overflow  <= overflow | ovf_err;
        underflow <= underflow | unf_err;
      end
    end
  end

endmodule
